// File: rtl/tcam_action_fifo.sv
// tcam_action_fifo
// Buffers TCAM lookup results ({hit, index}) ahead of an action stage.
// Storage is a DEPTH-entry circular buffer with first-word-fall-through
// output. In drop mode, misses are consumed without being stored and each
// one is counted in a saturating drop counter. Reset is synchronous and
// active-high.

module tcam_action_fifo #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tcam_valid,
  input  logic                     tcam_hit,
  input  logic [IDX_W-1:0]         tcam_hit_index,
  output logic                     tcam_ready,
  input  logic                     drop_miss,
  output logic                     action_valid,
  input  logic                     action_ready,
  output logic                     action_hit,
  output logic [IDX_W-1:0]         action_index,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] index;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;

  logic accept;
  logic pop;
  logic do_drop;
  logic do_write;

  // Ready and valid depend only on the registered count. This keeps
  // action_ready from reaching tcam_ready through combinational logic.
  assign tcam_ready   = (count != LW'(DEPTH));
  assign action_valid = (count != '0);
  assign level        = count;

  assign accept   = tcam_valid && tcam_ready;
  assign pop      = action_valid && action_ready;
  assign do_drop  = accept && drop_miss && !tcam_hit;
  assign do_write = accept && !do_drop;

  // Present the head entry, and drive zeros while the buffer is empty.
  always_comb begin
    // NOTE: every output is given a default before any condition is tested.
    // Without these defaults, a path that skips an assignment infers a latch.
    action_hit   = 1'b0;
    action_index = '0;
    if (action_valid) begin
      action_hit   = mem[rd_ptr].hit;
      action_index = mem[rd_ptr].index;
    end
  end

  // Write the entry storage. Contents outside the occupied range are never observed.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately left without a reset. The
    // pointers and count alone define which entries are valid, so leaving
    // the array unreset keeps it mappable to plain RAM.
    if (!rst && do_write) begin
      mem[wr_ptr] <= '{hit: tcam_hit, index: tcam_hit_index};
    end
  end

  // Update the pointers and occupancy. A write and a pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples the values from before the clock edge.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(do_write) - LW'(pop);
    end
  end

  // Count discarded misses. The counter saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (do_drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_tcam_action_fifo.sv
// tb_tcam_action_fifo
// Bench structure:
//   1. Table-driven vectors covering drop mode, forward mode and streaming.
//   2. Hand-written sequences: backpressure and full, reset mid-operation,
//      steady streaming at level 2, and counter saturation on a narrow
//      counter instance.
//   3. Random traffic checked against a queue-based reference model.

module tb_tcam_action_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       tcam_valid, tcam_hit, drop_miss, action_ready;
  logic [3:0] tcam_hit_index;
  logic       tcam_ready, action_valid, action_hit;
  logic [3:0] action_index;
  logic [2:0] level;
  logic [15:0] drop_cnt;

  // Second instance, with a 2-bit drop counter.
  logic       t2_valid, t2_hit, t2_drop_miss, t2_action_ready;
  logic [3:0] t2_hit_index;
  logic       t2_ready, t2_action_valid, t2_action_hit;
  logic [3:0] t2_action_index;
  logic [2:0] t2_level;
  logic [1:0] t2_drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tcam_action_fifo #(.IDX_W(4), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .tcam_valid(tcam_valid), .tcam_hit(tcam_hit), .tcam_hit_index(tcam_hit_index),
    .tcam_ready(tcam_ready), .drop_miss(drop_miss),
    .action_valid(action_valid), .action_ready(action_ready),
    .action_hit(action_hit), .action_index(action_index),
    .level(level), .drop_cnt(drop_cnt)
  );

  tcam_action_fifo #(.IDX_W(4), .DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .tcam_valid(t2_valid), .tcam_hit(t2_hit), .tcam_hit_index(t2_hit_index),
    .tcam_ready(t2_ready), .drop_miss(t2_drop_miss),
    .action_valid(t2_action_valid), .action_ready(t2_action_ready),
    .action_hit(t2_action_hit), .action_index(t2_action_index),
    .level(t2_level), .drop_cnt(t2_drop_cnt)
  );

  typedef struct {
    bit tv; bit hit; bit [3:0] idx; bit dm; bit ar;
    bit av; bit ah; bit [3:0] ai; bit [2:0] lvl; bit rdy; int dc;
  } vec_t;

  typedef struct packed { logic hit; logic [3:0] idx; } ent_t;

  vec_t vecs[14];
  ent_t model_q[$];
  int   model_dc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit tv, input bit hit, input bit [3:0] idx, input bit dm, input bit ar);
    tcam_valid = tv; tcam_hit = hit; tcam_hit_index = idx; drop_miss = dm; action_ready = ar;
  endtask

  task automatic check_outs(input string tag, input bit av, input bit ah, input bit [3:0] ai,
                            input bit [2:0] lvl, input bit rdy, input int dc);
    check({tag, ".action_valid"}, 32'(action_valid), 32'(av));
    check({tag, ".action_hit"},   32'(action_hit),   32'(ah));
    check({tag, ".action_index"}, 32'(action_index), 32'(ai));
    check({tag, ".level"},        32'(level),        32'(lvl));
    check({tag, ".tcam_ready"},   32'(tcam_ready),   32'(rdy));
    check({tag, ".drop_cnt"},     32'(drop_cnt),     32'(dc));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit [3:0] sent_idx[22];
    bit       sent_hit[22];
    int       exp2[5];
    int       exp_head[5];
    int       exp_lvl[5];
    int       exp_rdy[5];

    t2_valid = 0; t2_hit = 0; t2_hit_index = 0; t2_drop_miss = 0; t2_action_ready = 0;

    // Each vector gives the inputs for one cycle and the outputs expected during that cycle.
    //          tv hit idx dm ar   av ah ai lvl rdy dc
    vecs[0]  = '{1, 1, 7, 1, 1,   0, 0, 0, 0, 1, 0};
    vecs[1]  = '{1, 0, 2, 1, 1,   1, 1, 7, 1, 1, 0};
    vecs[2]  = '{1, 1, 9, 1, 1,   0, 0, 0, 0, 1, 1};
    vecs[3]  = '{1, 1, 7, 0, 1,   1, 1, 9, 1, 1, 1};
    vecs[4]  = '{1, 0, 2, 0, 1,   1, 1, 7, 1, 1, 1};
    vecs[5]  = '{1, 1, 9, 0, 1,   1, 0, 2, 1, 1, 1};
    vecs[6]  = '{0, 0, 0, 1, 1,   1, 1, 9, 1, 1, 1};
    vecs[7]  = '{0, 0, 0, 1, 1,   0, 0, 0, 0, 1, 1};
    vecs[8]  = '{0, 0, 5, 1, 1,   0, 0, 0, 0, 1, 1};
    vecs[9]  = '{1, 1, 1, 0, 1,   0, 0, 0, 0, 1, 1};
    vecs[10] = '{1, 1, 2, 0, 1,   1, 1, 1, 1, 1, 1};
    vecs[11] = '{1, 1, 3, 0, 1,   1, 1, 2, 1, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 1,   1, 1, 3, 1, 1, 1};
    vecs[13] = '{0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 1};

    // Check the reset state.
    do_reset();
    check_outs("reset", 0, 0, 0, 0, 1, 0);

    // Apply the vector table.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].tv, vecs[i].hit, vecs[i].idx, vecs[i].dm, vecs[i].ar);
      check_outs($sformatf("vec%0d", i), vecs[i].av, vecs[i].ah, vecs[i].ai,
                 vecs[i].lvl, vecs[i].rdy, vecs[i].dc);
      tick();
    end

    // Backpressure: the buffer fills, the 5th result is held off, then the buffer drains in order.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 4'(k), 0, 0);
      check($sformatf("bp_fill%0d.tcam_ready", k), 32'(tcam_ready), (k < 4) ? 1 : 0);
      check($sformatf("bp_fill%0d.level", k), 32'(level), (k < 4) ? k : 4);
      if (k > 0) check($sformatf("bp_fill%0d.head_stable", k), 32'(action_index), 0);
      tick();
    end
    exp_head = '{0, 1, 2, 3, 4};
    exp_lvl  = '{4, 3, 3, 2, 1};
    exp_rdy  = '{0, 1, 1, 1, 1};
    for (int k = 0; k < 5; k++) begin
      drive((k <= 1), 1, 4, 0, 1);
      check($sformatf("bp_drain%0d.action_index", k), 32'(action_index), 32'(exp_head[k]));
      check($sformatf("bp_drain%0d.level", k), 32'(level), 32'(exp_lvl[k]));
      check($sformatf("bp_drain%0d.tcam_ready", k), 32'(tcam_ready), 32'(exp_rdy[k]));
      tick();
    end
    check_outs("bp_empty", 0, 0, 0, 0, 1, 0);

    // Reset mid-operation: fill to level 3 with one drop, then reset while
    // presenting an accept, a pop and a miss.
    do_reset();
    drive(1, 1, 1, 1, 0); tick();
    drive(1, 1, 2, 1, 0); tick();
    drive(1, 0, 6, 1, 0); tick();
    drive(1, 1, 3, 1, 0); tick();
    check_outs("pre_rst", 1, 1, 1, 3, 1, 1);
    rst = 1'b1;
    drive(1, 0, 8, 1, 1);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 1);
    check_outs("mid_rst", 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post_rst%0d.action_valid", k), 32'(action_valid), 0);
    end

    // Steady streaming at level 2: the output trails the input by two entries.
    do_reset();
    for (int n = 0; n < 22; n++) begin
      sent_idx[n] = 4'((n * 5 + 3) % 16);
      sent_hit[n] = n[0];
    end
    drive(1, sent_hit[0], sent_idx[0], 0, 0); tick();
    drive(1, sent_hit[1], sent_idx[1], 0, 0); tick();
    for (int n = 2; n < 22; n++) begin
      drive(1, sent_hit[n], sent_idx[n], 0, 1);
      check($sformatf("stream%0d.level", n), 32'(level), 2);
      check($sformatf("stream%0d.action_index", n), 32'(action_index), 32'(sent_idx[n-2]));
      check($sformatf("stream%0d.action_hit", n), 32'(action_hit), 32'(sent_hit[n-2]));
      tick();
    end
    drive(0, 0, 0, 0, 0);

    // Saturation of the 2-bit drop counter.
    do_reset();
    exp2 = '{1, 2, 3, 3, 3};
    t2_valid = 1; t2_hit = 0; t2_drop_miss = 1; t2_action_ready = 1; t2_hit_index = 2;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("sat%0d.drop_cnt", k), 32'(t2_drop_cnt), 32'(exp2[k]));
      check($sformatf("sat%0d.action_valid", k), 32'(t2_action_valid), 0);
    end
    t2_valid = 0;

    // Random traffic against the queue model.
    do_reset();
    model_q.delete();
    model_dc = 0;
    for (int c = 0; c < 600; c++) begin
      bit r_rst, r_tv, r_hit, r_dm, r_ar, m_acc, m_pop;
      bit [3:0] r_idx;
      ent_t head;
      r_rst = ($urandom_range(0, 59) == 0);
      r_tv  = ($urandom_range(0, 3) != 0);
      r_hit = 1'($urandom_range(0, 1));
      r_idx = 4'($urandom_range(0, 15));
      r_dm  = 1'($urandom_range(0, 1));
      r_ar  = ($urandom_range(0, 2) != 0);
      rst = r_rst;
      drive(r_tv, r_hit, r_idx, r_dm, r_ar);
      head = (model_q.size() > 0) ? model_q[0] : '0;
      check_outs($sformatf("rnd%0d", c), (model_q.size() > 0), head.hit, head.idx,
                 3'(model_q.size()), (model_q.size() < 4), model_dc);
      m_acc = r_tv && (model_q.size() < 4);
      m_pop = r_ar && (model_q.size() > 0);
      if (r_rst) begin
        model_q.delete();
        model_dc = 0;
      end else begin
        if (m_pop) void'(model_q.pop_front());
        if (m_acc) begin
          if (r_dm && !r_hit) begin
            if (model_dc < 65535) model_dc++;
          end else begin
            model_q.push_back('{hit: r_hit, idx: r_idx});
          end
        end
      end
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcam_action_fifo.md
TCAM_ACTION_FIFO -- requirements
Module: tcam_action_fifo

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, giving the TCAM hit-index width in bits (range 1..16).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of buffer entries (power of 2, range 2..64).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the width of the drop counter.
REQ-004 Reset SHALL be decided as follows: one clock; reset is synchronous and active-high.
REQ-005 Port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst  input  1  synchronous reset, active-high.
REQ-007 Port tcam_valid  input  1  TCAM result valid.
REQ-008 Port tcam_hit  input  1  TCAM lookup hit flag.
REQ-009 Port tcam_hit_index  input  IDX_W  index of the matching entry.
REQ-010 Port tcam_ready  output  1  buffer can accept a result.
REQ-011 Port drop_miss  input  1  mode select: 1 discards misses, 0 forwards misses.
REQ-012 Port action_valid  output  1  head entry valid.
REQ-013 Port action_ready  input  1  action stage accepts the head entry.
REQ-014 Port action_hit  output  1  head entry hit flag.
REQ-015 Port action_index  output  IDX_W  head entry index.
REQ-016 Port level  output  clog2(DEPTH)+1  number of occupied entries.
REQ-017 Port drop_cnt  output  CNT_W  number of misses discarded.

Function
REQ-018 Storage SHALL be a DEPTH-entry circular buffer holding {hit, index}, with read and write pointers that wrap modulo DEPTH.
REQ-019 tcam_ready SHALL equal (level != DEPTH), and SHALL have no combinational path from action_ready.
REQ-020 Accept SHALL be defined as tcam_valid && tcam_ready; pop SHALL be defined as action_valid && action_ready.
REQ-021 An accept SHALL write the entry unless drop_miss && !tcam_hit; in that case the result is consumed but not stored.
REQ-022 Each dropped accept SHALL increment drop_cnt by 1, saturating at all-ones with no wrap.
REQ-023 action_valid SHALL equal (level != 0), and the output SHALL be first-word-fall-through from the read pointer.
REQ-024 action_hit and action_index SHALL be 0 whenever action_valid is 0.
REQ-025 Latency SHALL be exactly one cycle: a write at edge N makes action_valid high after edge N, and there SHALL be no combinational input-to-output bypass.
REQ-026 A write and a pop in the same cycle SHALL leave level unchanged, giving full throughput of 1 entry per cycle at any level below DEPTH.
REQ-027 When full, tcam_ready SHALL be 0 even if action_ready is 1; the pop takes effect and tcam_ready rises the following cycle.
REQ-028 When empty with tcam_valid=1, the entry SHALL be accepted; no pop occurs in the same cycle.
REQ-029 Entries SHALL leave in acceptance order, and hit and miss entries SHALL share a single queue.
REQ-030 While action_valid=1 and action_ready=0, action_hit and action_index SHALL remain stable.
REQ-031 drop_miss SHALL be sampled per accept cycle, so a mode change affects only subsequent accepts.
REQ-032 Entry contents outside the occupied range SHALL be don't-care and need no reset.

Reset
REQ-033 While rst=1 at a clock edge, the pointers, level, and drop_cnt SHALL clear to 0.
REQ-034 After reset, action_valid, action_hit, and action_index SHALL be 0 and tcam_ready SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL flush all stored entries, with no entry emitted after reset deasserts.
REQ-036 Accepts and pops presented in a reset cycle SHALL be ignored, and drop_cnt SHALL not increment.

Verification
REQ-037 Scenario: with action_ready=1, send hits with index 1,2,3 on consecutive cycles -> action_valid high cycles 2-4 carrying 1,2,3; level never exceeds 1.
REQ-038 Scenario: with action_ready=0, send 5 results (DEPTH=4) -> 4 accepted, tcam_ready low from cycle 5, level=4; raise action_ready -> entries 0..3 out in order; the 5th is accepted the cycle after the first pop.
REQ-039 Scenario: with drop_miss=1, send hit 7, miss 2, hit 9 -> output shows only 7 then 9, drop_cnt=1; repeat with drop_miss=0 -> three entries out, miss carrying action_hit=0, index=2.
REQ-040 Scenario: with CNT_W=2 and drop_miss=1, send 5 misses -> drop_cnt reads 1,2,3,3,3 and action_valid stays 0.
REQ-041 Scenario: with level=3, assert rst for one cycle -> next cycle level=0, action_valid=0, drop_cnt=0, and no stale entry is ever emitted.
REQ-042 Scenario: with level=2, hold tcam_valid=1 and action_ready=1 continuously for 20 cycles -> level stays 2, and the output sequence equals the input sequence delayed by 2 entries.
